// File: rtl/graphic_command_sender_if.sv
// Command/stream/UART/status bundle for graphic_command_sender.
//   Cmd*    : command request handshake (CmdValid/CmdReady + opcode/color/addr)
//   Pix*    : stream pixel handshake (PixValid/PixReady + color)
//   Tx*     : UART transmitter byte interface (TxEnable pulse, TxReady from UART)
//   Rx*     : UART receiver byte interface (RxReady marks a valid RxData byte)
//   Status  : Done/Error pulses, Busy level, Retries count
// slave modport = the sender block; master modport = the requester/UART side.
interface graphic_command_sender_if;
  logic        CmdValid;
  logic        CmdReady;
  logic [3:0]  CmdOpcode;
  logic [2:0]  CmdColor;
  logic [16:0] CmdAddr;
  logic        PixValid;
  logic        PixReady;
  logic [2:0]  PixColor;
  logic [7:0]  TxData;
  logic        TxEnable;
  logic        TxReady;
  logic [7:0]  RxData;
  logic        RxReady;
  logic        Done;
  logic        Error;
  logic        Busy;
  logic [1:0]  Retries;

  modport slave (
    input  CmdValid, CmdOpcode, CmdColor, CmdAddr,
    input  PixValid, PixColor,
    input  TxReady, RxData, RxReady,
    output CmdReady, PixReady, TxData, TxEnable,
    output Done, Error, Busy, Retries
  );

  modport master (
    output CmdValid, CmdOpcode, CmdColor, CmdAddr,
    output PixValid, PixColor,
    output TxReady, RxData, RxReady,
    input  CmdReady, PixReady, TxData, TxEnable,
    input  Done, Error, Busy, Retries
  );
endinterface

// File: rtl/graphic_command_sender.sv
// Sends a 24-bit command {opcode,color,addr} to a graphic card over a UART
// byte interface, waits for an acknowledge byte with timeout/retry, and for
// STREAM commands forwards STREAM_PIXELS pixel bytes, each individually acked.
// Ports:
//   Clk : clock
//   Rst : synchronous active-high reset
//   bus : graphic_command_sender_if.slave (command, pixel, UART, status)
module graphic_command_sender #(
  parameter logic [7:0]  ACK_BYTE      = 8'd42,
  parameter int unsigned ACK_TIMEOUT   = 500_000,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned STREAM_PIXELS = 120_000
) (
  input logic                     Clk,
  input logic                     Rst,
  graphic_command_sender_if.slave bus
);

  localparam int unsigned TMO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PIX_W     = 17;
  localparam int unsigned WORD_W    = 24;
  localparam logic [3:0]  OP_STREAM = 4'b0011;

  typedef enum logic [2:0] {
    IDLE, SEND, CMD_ACK, PIX_WAIT, PIX_SEND, PIX_ACK, FINAL_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [1:0]          retries_q, retries_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic                wait_low_q, wait_low_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_enable_q, tx_enable_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                pix_ready_q, pix_ready_d;

  logic                rx_ack;
  logic                tmo_hit;
  logic                can_send;
  logic [7:0]          cur_byte;

  assign rx_ack   = bus.RxReady && (bus.RxData == ACK_BYTE);
  assign tmo_hit  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
  // wait_low_q holds off the next byte until the UART has dropped TxReady
  // after the previous pulse; TxReady only falls in response to TxEnable.
  assign can_send = bus.TxReady && !wait_low_q;
  assign cur_byte = (byte_idx_q == 2'd0) ? word_q[23:16] :
                    (byte_idx_q == 2'd1) ? word_q[15:8]  : word_q[7:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    retries_d   = retries_q;
    tmo_d       = tmo_q;
    pix_cnt_d   = pix_cnt_q;
    wait_low_d  = wait_low_q;
    tx_data_d   = tx_data_q;
    tx_enable_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    if (!bus.TxReady) wait_low_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.CmdValid) begin
          word_d     = {bus.CmdOpcode, bus.CmdColor, bus.CmdAddr};
          byte_idx_d = 2'd0;
          retries_d  = 2'd0;
          pix_cnt_d  = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (can_send) begin
          tx_enable_d = 1'b1;
          wait_low_d  = 1'b1;
          tx_data_d   = cur_byte;
          if (byte_idx_q == 2'd2) begin
            tmo_d   = '0;
            state_d = CMD_ACK;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      CMD_ACK: begin
        // An ack in the expiring cycle still counts as an ack.
        if (rx_ack) begin
          if (word_q[23:20] == OP_STREAM) begin
            state_d = PIX_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          if (32'(retries_q) < MAX_RETRIES) begin
            retries_d  = retries_q + 2'd1;
            byte_idx_d = 2'd0;
            state_d    = SEND;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      PIX_WAIT: begin
        if (bus.PixValid) begin
          tx_data_d = {bus.PixColor, 5'b0};
          state_d   = PIX_SEND;
        end
      end
      PIX_SEND: begin
        if (can_send) begin
          tx_enable_d = 1'b1;
          wait_low_d  = 1'b1;
          tmo_d       = '0;
          state_d     = PIX_ACK;
        end
      end
      PIX_ACK: begin
        if (rx_ack) begin
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          tmo_d     = '0;
          if (pix_cnt_q + PIX_W'(1) == PIX_W'(STREAM_PIXELS)) state_d = FINAL_ACK;
          else                                                state_d = PIX_WAIT;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      FINAL_ACK: begin
        if (rx_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Level outputs follow the state being entered so they line up with state_q.
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
    pix_ready_d = (state_d == PIX_WAIT);
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_idx_q  <= 2'd0;
      retries_q   <= 2'd0;
      tmo_q       <= '0;
      pix_cnt_q   <= '0;
      wait_low_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_enable_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      pix_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      retries_q   <= retries_d;
      tmo_q       <= tmo_d;
      pix_cnt_q   <= pix_cnt_d;
      wait_low_q  <= wait_low_d;
      tx_data_q   <= tx_data_d;
      tx_enable_q <= tx_enable_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      pix_ready_q <= pix_ready_d;
    end
  end

  assign bus.TxData   = tx_data_q;
  assign bus.TxEnable = tx_enable_q;
  assign bus.Done     = done_q;
  assign bus.Error    = error_q;
  assign bus.Busy     = busy_q;
  assign bus.CmdReady = cmd_ready_q;
  assign bus.PixReady = pix_ready_q;
  assign bus.Retries  = retries_q;

endmodule

// File: tb/tb_graphic_command_sender.sv
// Directed bench for graphic_command_sender: a small UART model logs every
// TxEnable byte and drops TxReady for a few cycles; acks are driven by hand.
module tb_graphic_command_sender;

  logic clk;
  logic rst;

  graphic_command_sender_if bus ();

  graphic_command_sender #(
    .ACK_BYTE      (8'd42),
    .ACK_TIMEOUT   (100),
    .MAX_RETRIES   (3),
    .STREAM_PIXELS (4)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks   = 0;
  int          errors   = 0;
  int          tx_busy  = 0;
  logic        tx_block = 1'b0;
  logic [7:0]  tx_log[$];
  int          tx_viol  = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          both_cnt = 0;

  assign bus.TxReady = (tx_busy == 0) && !tx_block;

  // UART transmitter model and status pulse counters.
  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 0;
    end else if (bus.TxEnable) begin
      tx_log.push_back(bus.TxData);
      if (!bus.TxReady) tx_viol <= tx_viol + 1;
      tx_busy <= 4;
    end else if (tx_busy != 0) begin
      tx_busy <= tx_busy - 1;
    end
    if (bus.Done)              done_cnt <= done_cnt + 1;
    if (bus.Error)             err_cnt  <= err_cnt + 1;
    if (bus.Done && bus.Error) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic [3:0] op, input logic [2:0] col, input logic [16:0] addr);
    @(negedge clk);
    bus.CmdOpcode = op;
    bus.CmdColor  = col;
    bus.CmdAddr   = addr;
    bus.CmdValid  = 1'b1;
    @(negedge clk);
    bus.CmdValid  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.RxData  = b;
    bus.RxReady = 1'b1;
    @(negedge clk);
    bus.RxReady = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
    check(tag, 32'(tx_log.size()), 32'(n));
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    for (int i = 0; i < budget && done_cnt == base; i++) @(negedge clk);
    check(tag, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_pix_ready(input string tag, input int budget);
    for (int i = 0; i < budget && bus.PixReady !== 1'b1; i++) @(negedge clk);
    check(tag, 32'(bus.PixReady), 32'd1);
  endtask

  logic [7:0] exp3[3];
  logic [2:0] pix_col[4];
  logic [7:0] pix_exp[4];
  int base_tx, base_done, base_err;

  initial begin
    bus.CmdValid  = 1'b0;
    bus.CmdOpcode = 4'd0;
    bus.CmdColor  = 3'd0;
    bus.CmdAddr   = 17'd0;
    bus.PixValid  = 1'b0;
    bus.PixColor  = 3'd0;
    bus.RxData    = 8'd0;
    bus.RxReady   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Outputs while reset is held.
    check("rst_cmd_ready", 32'(bus.CmdReady), 32'd1);
    check("rst_busy",      32'(bus.Busy),     32'd0);
    check("rst_tx_en",     32'(bus.TxEnable), 32'd0);
    check("rst_tx_data",   32'(bus.TxData),   32'd0);
    check("rst_done",      32'(bus.Done),     32'd0);
    check("rst_error",     32'(bus.Error),    32'd0);
    check("rst_retries",   32'(bus.Retries),  32'd0);
    check("rst_pix_ready", 32'(bus.PixReady), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(bus.CmdReady), 32'd1);

    // Ack byte while idle is discarded.
    send_rx(8'd42);
    @(negedge clk);
    check("idle_rx_busy", 32'(bus.Busy), 32'd0);
    check("idle_rx_done", 32'(done_cnt), 32'd0);

    // PUT opcode 2, color 5, addr 1_0203 -> 2B 02 03, ack -> Done.
    base_done = done_cnt;
    issue_cmd(4'd2, 3'b101, 17'h1_0203);
    check("put_busy",      32'(bus.Busy),     32'd1);
    check("put_cmd_ready", 32'(bus.CmdReady), 32'd0);
    wait_tx("put_tx_count", 3, 200);
    exp3 = '{8'h2B, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) check($sformatf("put_byte%0d", i), 32'(tx_log[i]), 32'(exp3[i]));
    send_rx(8'd42);
    wait_done("put_done", base_done, 20);
    @(negedge clk);
    check("put_idle_ready", 32'(bus.CmdReady), 32'd1);
    check("put_idle_busy",  32'(bus.Busy),     32'd0);

    // Wrong byte 0x41 is ignored, then 42 completes.
    base_tx = tx_log.size(); base_done = done_cnt;
    issue_cmd(4'd1, 3'd0, 17'h0_0005);
    wait_tx("echo41_tx_count", base_tx + 3, 200);
    exp3 = '{8'h10, 8'h00, 8'h05};
    for (int i = 0; i < 3; i++) check($sformatf("echo41_byte%0d", i), 32'(tx_log[base_tx+i]), 32'(exp3[i]));
    send_rx(8'h41);
    repeat (3) @(negedge clk);
    check("echo41_still_busy", 32'(bus.Busy), 32'd1);
    check("echo41_no_done",    32'(done_cnt - base_done), 32'd0);
    send_rx(8'd42);
    wait_done("echo41_done", base_done, 20);

    // No ack: 4 transmissions, Retries 3, one Error.
    base_tx = tx_log.size(); base_done = done_cnt; base_err = err_cnt;
    issue_cmd(4'd1, 3'b111, 17'h0_ABCD);
    for (int i = 0; i < 2000 && err_cnt == base_err; i++) @(negedge clk);
    check("retry_error_pulses", 32'(err_cnt - base_err), 32'd1);
    check("retry_tx_count",     32'(tx_log.size() - base_tx), 32'd12);
    exp3 = '{8'h1E, 8'hAB, 8'hCD};
    for (int i = 0; i < 12; i++) check($sformatf("retry_byte%0d", i), 32'(tx_log[base_tx+i]), 32'(exp3[i%3]));
    check("retry_count",   32'(bus.Retries), 32'd3);
    check("retry_no_done", 32'(done_cnt - base_done), 32'd0);
    @(negedge clk);
    check("retry_idle", 32'(bus.CmdReady), 32'd1);

    // STREAM with 4 pixels.
    base_tx = tx_log.size(); base_done = done_cnt; base_err = err_cnt;
    issue_cmd(4'd3, 3'd0, 17'h0_0000);
    wait_tx("stream_cmd_count", base_tx + 3, 200);
    exp3 = '{8'h30, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) check($sformatf("stream_cmd_byte%0d", i), 32'(tx_log[base_tx+i]), 32'(exp3[i]));
    send_rx(8'd42);
    pix_col = '{3'd1, 3'd2, 3'd3, 3'd7};
    pix_exp = '{8'h20, 8'h40, 8'h60, 8'hE0};
    for (int p = 0; p < 4; p++) begin
      wait_pix_ready($sformatf("stream_pix_ready%0d", p), 50);
      bus.PixColor = pix_col[p];
      bus.PixValid = 1'b1;
      @(negedge clk);
      bus.PixValid = 1'b0;
      check($sformatf("stream_pix_ready_low%0d", p), 32'(bus.PixReady), 32'd0);
      wait_tx($sformatf("stream_pix_count%0d", p), base_tx + 4 + p, 50);
      check($sformatf("stream_pix_byte%0d", p), 32'(tx_log[base_tx+3+p]), 32'(pix_exp[p]));
      send_rx(8'd42);
    end
    @(negedge clk);
    check("stream_final_busy",    32'(bus.Busy), 32'd1);
    check("stream_final_no_done", 32'(done_cnt - base_done), 32'd0);
    send_rx(8'd42);
    wait_done("stream_done", base_done, 20);
    check("stream_no_error", 32'(err_cnt - base_err), 32'd0);

    // TxReady held low for 50 cycles: nothing sent until it rises, no duplicates.
    base_tx = tx_log.size(); base_done = done_cnt;
    tx_block = 1'b1;
    issue_cmd(4'd5, 3'd1, 17'h0_0001);
    repeat (50) @(negedge clk);
    check("block_no_tx", 32'(tx_log.size() - base_tx), 32'd0);
    tx_block = 1'b0;
    wait_tx("block_tx_count", base_tx + 3, 200);
    repeat (10) @(negedge clk);
    check("block_no_dup", 32'(tx_log.size() - base_tx), 32'd3);
    exp3 = '{8'h52, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) check($sformatf("block_byte%0d", i), 32'(tx_log[base_tx+i]), 32'(exp3[i]));
    send_rx(8'd42);
    wait_done("block_done", base_done, 20);

    // Reset after the second byte aborts silently; a new command starts at byte 0.
    base_tx = tx_log.size(); base_done = done_cnt; base_err = err_cnt;
    issue_cmd(4'd6, 3'd2, 17'h0_0304);
    wait_tx("abort_two_bytes", base_tx + 2, 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cmd_ready", 32'(bus.CmdReady), 32'd1);
    check("abort_busy",      32'(bus.Busy),     32'd0);
    check("abort_tx_data",   32'(bus.TxData),   32'd0);
    check("abort_tx_en",     32'(bus.TxEnable), 32'd0);
    check("abort_retries",   32'(bus.Retries),  32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_more_tx", 32'(tx_log.size() - base_tx), 32'd2);
    check("abort_no_done",    32'(done_cnt - base_done),    32'd0);
    check("abort_no_error",   32'(err_cnt - base_err),      32'd0);
    base_tx = tx_log.size();
    issue_cmd(4'd2, 3'b101, 17'h1_0203);
    wait_tx("restart_tx_count", base_tx + 3, 200);
    exp3 = '{8'h2B, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) check($sformatf("restart_byte%0d", i), 32'(tx_log[base_tx+i]), 32'(exp3[i]));
    send_rx(8'd42);
    wait_done("restart_done", base_done, 20);

    // Global protocol properties.
    check("tx_only_when_ready", 32'(tx_viol),  32'd0);
    check("done_error_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/graphic_command_sender.md
GRAPHIC_COMMAND_SENDER -- requirements
Module: graphic_command_sender

Interface
REQ-001 SHALL have parameter ACK_BYTE, default 8'd42, the acknowledge byte expected from the graphic card.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 500_000, the clock cycles allowed per acknowledge wait.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, the resends of a command after an ack timeout.
REQ-004 SHALL have parameter STREAM_PIXELS, default 120_000, the pixel bytes sent after a STREAM command.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock.
REQ-006 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports CmdValid input 1, CmdReady output 1, CmdOpcode input 4, CmdColor input 3, CmdAddr input 17: the command request handshake.
REQ-008 SHALL have ports PixValid input 1, PixReady output 1, PixColor input 3: the stream pixel handshake.
REQ-009 SHALL have ports TxData output 8, TxEnable output 1, TxReady input 1: the UART transmitter byte interface.
REQ-010 SHALL have ports RxData input 8, RxReady input 1: the UART receiver byte interface, where RxReady high means the byte is valid that cycle.
REQ-011 SHALL have ports Done output 1, Error output 1, Busy output 1, Retries output 2: the status outputs.

Function
REQ-012 SHALL use states IDLE, SEND, CMD_ACK, PIX_WAIT, PIX_SEND, PIX_ACK, FINAL_ACK.
REQ-013 IDLE: CmdReady=1; a cycle with CmdValid=1 SHALL latch word={CmdOpcode,CmdColor,CmdAddr} (24 bits), set the byte index to 0, clear the retry count, and go to SEND.
REQ-014 SEND SHALL transmit word[23:16], then word[15:8], then word[7:0], most significant byte first.
REQ-015 Each byte SHALL be sent as a one-cycle TxEnable pulse with TxData stable in that cycle, issued only while TxReady=1.
REQ-016 After each pulse, the next byte SHALL wait until TxReady has been seen low and then high again.
REQ-017 After the third byte, the block SHALL go to CMD_ACK with the timeout counter at 0.
REQ-018 CMD_ACK: RxReady with RxData==ACK_BYTE SHALL go to PIX_WAIT if opcode==4'b0011 (STREAM), otherwise pulse Done for 1 cycle and return to IDLE.
REQ-019 In any ack state, an RxReady byte not equal to ACK_BYTE SHALL be ignored and SHALL NOT reset the timeout.
REQ-020 CMD_ACK timeout (counter reaching ACK_TIMEOUT) with Retries<MAX_RETRIES SHALL increment Retries and resend all 3 bytes from byte 0.
REQ-021 CMD_ACK timeout with Retries==MAX_RETRIES SHALL pulse Error for 1 cycle and return to IDLE.
REQ-022 PIX_WAIT: PixReady=1; PixValid=1 SHALL latch TxData={PixColor,5'b0} and go to PIX_SEND.
REQ-023 PIX_SEND SHALL issue a single byte under REQ-015/REQ-016 and then go to PIX_ACK.
REQ-024 PIX_ACK: an ack SHALL increment the pixel counter (17 bits); on reaching STREAM_PIXELS go to FINAL_ACK, otherwise go to PIX_WAIT.
REQ-025 PIX_ACK and FINAL_ACK timeouts SHALL NOT retry: they SHALL pulse Error and return to IDLE.
REQ-026 FINAL_ACK: an ack SHALL pulse Done and return to IDLE.
REQ-027 Busy SHALL be 1 in every state except IDLE; CmdReady SHALL be 0 in every state except IDLE; PixReady SHALL be 0 in every state except PIX_WAIT.
REQ-028 If RxReady arrives in the same cycle the timeout expires, the ack SHALL take priority.
REQ-029 Rx bytes arriving in IDLE, SEND, PIX_WAIT or PIX_SEND SHALL be discarded.
REQ-030 Done and Error SHALL never be asserted in the same cycle.

Reset
REQ-031 Rst=1 at a rising Clk edge SHALL force IDLE and set TxEnable=0, TxData=0, Done=0, Error=0, Busy=0, Retries=0, PixReady=0, and clear all counters; CmdReady SHALL be 1 from the first cycle after reset.
REQ-032 Rst asserted mid-command or mid-stream SHALL abort with no Done/Error pulse and no further TxEnable.

Verification
REQ-033 PUT opcode 2, color 3'b101, addr 17'h1_0203 -> TxData 8'h2B, 8'h02, 8'h03 in order; ack 42 -> one Done pulse, then IDLE.
REQ-034 ECHO command with no ack, ACK_TIMEOUT=100 -> 4 transmissions of 3 bytes, Retries reaching 3, then one Error pulse.
REQ-035 Byte 8'h41 followed by 42 during CMD_ACK -> 8'h41 ignored, Done on the 42.
REQ-036 STREAM with STREAM_PIXELS=4, PixColor 1,2,3,7 -> TxData 8'h20, 8'h40, 8'h60, 8'hE0, each acked; the final ack gives Done.
REQ-037 TxReady held low for 50 cycles -> no TxEnable until it rises, and no duplicate byte.
REQ-038 Rst pulse after the second byte -> IDLE with all outputs at reset values; a new command then sends byte 0 first.
